soft_gamma_engine: RTL and testbench

//  Sequential fixed-point successor of the combinational real-valued gamma unit. Computes the

---
 rtl/soft_gamma_pkg.sv | 28 ++
 rtl/soft_gamma_engine_qmul.sv | 18 +
 rtl/soft_gamma_engine.sv | 260 ++++++++++++++++++++++++++
 tb/tb_soft_gamma_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/soft_gamma_pkg.sv
// Shared types and constants for the IDS drift-channel gamma engine.
// Holds the FSM state enum, default Q0.16 probabilities and a mul helper.
package soft_gamma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int PROB_W_DEF = 16;
    localparam int P_D_DEF    = 21845;
    localparam int P_IH_DEF   = 10923;
    localparam int P_T_DEF    = 21845;
    localparam int P_S_DEF    = 21845;
    localparam int P_NS_DEF   = 43691;

    // (a*b) >> PROB_W with truncation; b may carry the Q1 "1.0" bit.
    function automatic logic [PROB_W_DEF:0] mul(
        input logic [PROB_W_DEF-1:0] a,
        input logic [PROB_W_DEF:0]   b
    );
        logic [2*PROB_W_DEF:0] p;
        p = {{(PROB_W_DEF+1){1'b0}}, a} * {{PROB_W_DEF{1'b0}}, b};
        return (PROB_W_DEF+1)'(p >> PROB_W_DEF);
    endfunction

endpackage

// File: rtl/soft_gamma_engine_qmul.sv
// Combinational truncating fixed-point multiplier: p = (a*b) >> PROB_W.
// Ports: a (Q0.PROB_W), b (Q1.PROB_W), p (Q1.PROB_W result).
module gamma_qmul
    import soft_gamma_pkg::*;
#(
    parameter int PROB_W = PROB_W_DEF
) (
    input  logic [PROB_W-1:0] a,
    input  logic [PROB_W:0]   b,
    output logic [PROB_W:0]   p
);

    logic [2*PROB_W:0] full;

    assign full = {{(PROB_W+1){1'b0}}, a} * {{PROB_W{1'b0}}, b};
    assign p    = (PROB_W+1)'(full >> PROB_W);

endmodule

// File: rtl/soft_gamma_engine.sv
// Sequential IDS drift-channel branch metric gamma(t,d->d_tag,b), single or sweep.
// Ports: clk/rst_n, r_load/r_in/n_len, req_* (valid/ready), out_* (valid/ready), busy.
// Optional GAMMA_STATS_EN adds stat_req_cnt / stat_zero_cnt saturating counters.
module soft_gamma_engine
    import soft_gamma_pkg::*;
#(
    parameter int MAX_N  = 32,
    parameter int DMAX   = 4,
    parameter int IMAX   = 2,
    parameter int PROB_W = PROB_W_DEF,
    parameter int T_W    = 8,
    parameter int D_W    = 6,
    parameter int P_D_Q  = P_D_DEF,
    parameter int P_IH_Q = P_IH_DEF,
    parameter int P_T_Q  = P_T_DEF,
    parameter int P_S_Q  = P_S_DEF,
    parameter int P_NS_Q = P_NS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r_load,
    input  logic [MAX_N-1:0]  r_in,
    input  logic [T_W-1:0]    n_len,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [T_W-1:0]    req_t,
    input  logic [D_W-1:0]    req_d,
    input  logic [D_W-1:0]    req_dtag,
    input  logic              req_b,
    input  logic              req_sweep,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROB_W-1:0] out_gamma,
    output logic [D_W-1:0]    out_dtag,
    output logic              out_last,
    output logic              busy
`ifdef GAMMA_STATS_EN
    ,
    output logic [15:0]       stat_req_cnt,
    output logic [15:0]       stat_zero_cnt
`endif
);

    // Drifts are kept two bits wider so d-1 and d+IMAX never wrap.
    localparam int SW = D_W + 2;
    localparam int IW = ((T_W > SW) ? T_W : SW) + 2;
    localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic signed [SW-1:0] ONE_S  = SW'(1);
    localparam logic signed [SW-1:0] DMAX_S = SW'(DMAX);
    localparam logic signed [SW-1:0] IMAX_S = SW'(IMAX);
    localparam logic signed [IW-1:0] ONE_I  = IW'(1);

    localparam logic [PROB_W-1:0] P_D  = PROB_W'(P_D_Q);
    localparam logic [PROB_W-1:0] P_IH = PROB_W'(P_IH_Q);
    localparam logic [PROB_W-1:0] P_T  = PROB_W'(P_T_Q);
    localparam logic [PROB_W-1:0] P_S  = PROB_W'(P_S_Q);
    localparam logic [PROB_W-1:0] P_NS = PROB_W'(P_NS_Q);
    localparam logic [PROB_W:0]   ONE_P = {1'b1, {PROB_W{1'b0}}};

    state_t state_q, state_d;

    logic [T_W-1:0]        t_q;
    logic signed [SW-1:0]  d_q;
    logic signed [SW-1:0]  dtag_q;
    logic                  b_q;
    logic                  sweep_q;
    logic [PROB_W:0]       pow_q;
    logic [SW-1:0]         cnt_q;
    logic [MAX_N-1:0]      r_q;
    logic [T_W-1:0]        n_q;

    logic                  req_fire;
    logic                  out_fire;
    logic signed [SW-1:0]  d_in;
    logic signed [SW-1:0]  dtag_in;
    logic signed [SW-1:0]  delta_in;
    logic                  calc_in;

    logic signed [SW-1:0]  delta;
    logic signed [SW-1:0]  hi;
    logic signed [IW-1:0]  t_ext;
    logic signed [IW-1:0]  d_ext;
    logic signed [IW-1:0]  dt_ext;
    logic signed [IW-1:0]  n_ext;
    logic signed [IW-1:0]  lo;
    logic signed [IW-1:0]  idx;
    logic                  in_bound;
    logic                  del_ok;
    logic                  ins_ok;
    logic                  hit;
    logic                  last_c;
    logic [PROB_W-1:0]     ch_a;
    logic [PROB_W:0]       pow_nx;
    logic [PROB_W:0]       tr_p;
    logic [PROB_W:0]       ch_p;
    logic [PROB_W-1:0]     gamma_c;

    // Request side
    assign req_ready = (state_q == IDLE) && !r_load;
    assign req_fire  = req_valid && req_ready;

    assign d_in     = {{(SW-D_W){req_d[D_W-1]}}, req_d};
    assign dtag_in  = req_sweep ? (d_in - ONE_S)
                                : {{(SW-D_W){req_dtag[D_W-1]}}, req_dtag};
    assign delta_in = dtag_in - d_in;

    // Only single requests with 1..IMAX insertions need CALC cycles.
    assign calc_in = !req_sweep && !delta_in[SW-1]
                     && (delta_in != '0) && (delta_in <= IMAX_S);

    // Metric evaluation on the registered request
    assign delta  = dtag_q - d_q;
    assign t_ext  = {{(IW-T_W){1'b0}}, t_q};
    assign d_ext  = {{(IW-SW){d_q[SW-1]}}, d_q};
    assign dt_ext = {{(IW-SW){dtag_q[SW-1]}}, dtag_q};
    assign n_ext  = {{(IW-T_W){1'b0}}, n_q};
    assign lo     = t_ext - ONE_I + d_ext;
    assign idx    = t_ext - ONE_I + dt_ext;

    assign in_bound = (d_q >= -DMAX_S) && (d_q <= DMAX_S)
                      && (dtag_q >= -DMAX_S) && (dtag_q <= DMAX_S);

    assign del_ok = (delta == -ONE_S) && !lo[IW-1] && (lo <= n_ext);

    // idx >= lo whenever delta >= 0, so idx < n_len keeps r indexing legal.
    assign ins_ok = !delta[SW-1] && (delta <= IMAX_S)
                    && !lo[IW-1] && (idx < n_ext);

    assign hit  = (r_q[idx[AW-1:0]] == b_q);
    assign ch_a = hit ? P_NS : P_S;

    gamma_qmul #(.PROB_W(PROB_W)) u_pow (
        .a (P_IH),
        .b (pow_q),
        .p (pow_nx)
    );

    gamma_qmul #(.PROB_W(PROB_W)) u_tr (
        .a (P_T),
        .b (pow_q),
        .p (tr_p)
    );

    gamma_qmul #(.PROB_W(PROB_W)) u_ch (
        .a (ch_a),
        .b (tr_p),
        .p (ch_p)
    );

    always_comb begin
        gamma_c = '0;
        if (in_bound && del_ok) begin
            gamma_c = P_D;
        end else if (in_bound && ins_ok) begin
            gamma_c = PROB_W'(ch_p);
        end
    end

    // Sweep ends at min(d+IMAX, DMAX); an empty range ends immediately.
    assign hi     = ((d_q + IMAX_S) < DMAX_S) ? (d_q + IMAX_S) : DMAX_S;
    assign last_c = !sweep_q || (dtag_q >= hi);

    // Outputs
    assign out_valid = (state_q == OUT);
    assign out_fire  = out_valid && out_ready;
    assign out_gamma = out_valid ? gamma_c : '0;
    assign out_last  = out_valid && last_c;
    assign out_dtag  = D_W'(dtag_q);
    assign busy      = (state_q != IDLE);

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = calc_in ? CALC : OUT;
                end
            end
            CALC: begin
                if (cnt_q == SW'(1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready && last_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q     <= '0;
            d_q     <= '0;
            dtag_q  <= '0;
            b_q     <= 1'b0;
            sweep_q <= 1'b0;
            pow_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            n_q     <= '0;
        end else begin
            if ((state_q == IDLE) && r_load) begin
                r_q <= r_in;
                n_q <= n_len;
            end
            if (req_fire) begin
                t_q     <= req_t;
                d_q     <= d_in;
                dtag_q  <= dtag_in;
                b_q     <= req_b;
                sweep_q <= req_sweep;
                pow_q   <= ONE_P;
                cnt_q   <= calc_in ? delta_in : '0;
            end
            if (state_q == CALC) begin
                pow_q <= pow_nx;
                cnt_q <= cnt_q - SW'(1);
            end
            // Next sweep step: one more insertion factor once delta >= 1.
            if (out_fire && !last_c) begin
                dtag_q <= dtag_q + ONE_S;
                if (!delta[SW-1]) begin
                    pow_q <= pow_nx;
                end
            end
        end
    end

`ifdef GAMMA_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_req_cnt  <= '0;
            stat_zero_cnt <= '0;
        end else begin
            if (req_fire && (stat_req_cnt != 16'hFFFF)) begin
                stat_req_cnt <= stat_req_cnt + 16'd1;
            end
            if (out_fire && (gamma_c == '0)
                && (stat_zero_cnt != 16'hFFFF)) begin
                stat_zero_cnt <= stat_zero_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_soft_gamma_engine.sv
// Self-checking bench for soft_gamma_engine against an arithmetic model.
// Directed spec cases, stall, mid-request reset, then random requests.
module tb_soft_gamma_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r_load;
    logic [31:0] r_in;
    logic [7:0]  n_len;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_t;
    logic [5:0]  req_d;
    logic [5:0]  req_dtag;
    logic        req_b;
    logic        req_sweep;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_gamma;
    logic [5:0]  out_dtag;
    logic        out_last;
    logic        busy;
`ifdef GAMMA_STATS_EN
    logic [15:0] stat_req_cnt;
    logic [15:0] stat_zero_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] r_m;
    int          n_m;

    always #5 clk = ~clk;

    soft_gamma_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r_load    (r_load),
        .r_in      (r_in),
        .n_len     (n_len),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_t     (req_t),
        .req_d     (req_d),
        .req_dtag  (req_dtag),
        .req_b     (req_b),
        .req_sweep (req_sweep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gamma (out_gamma),
        .out_dtag  (out_dtag),
        .out_last  (out_last),
        .busy      (busy)
`ifdef GAMMA_STATS_EN
        ,
        .stat_req_cnt  (stat_req_cnt),
        .stat_zero_cnt (stat_zero_cnt)
`endif
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Branch metric straight from the channel rules, in plain integers.
    function automatic int gref(input int t, input int d,
                                input int dt, input int b);
        int     delta, lo, idx, bit_r;
        longint p, g;
        if (d < -4 || d > 4 || dt < -4 || dt > 4) return 0;
        delta = dt - d;
        lo    = t - 1 + d;
        idx   = t - 1 + dt;
        if (delta == -1) return (lo >= 0 && lo <= n_m) ? 21845 : 0;
        if (delta < 0 || delta > 2) return 0;
        if (lo < 0 || idx > n_m - 1) return 0;
        p = 65536;
        for (int k = 0; k < delta; k++) p = (p * 10923) >> 16;
        g = (p * 21845) >> 16;
        bit_r = int'((r_m >> idx) & 32'd1);
        g = (g * ((bit_r == b) ? 43691 : 21845)) >> 16;
        return int'(g);
    endfunction

    task automatic load_r(input logic [31:0] r, input int n);
        r_load = 1'b1;
        r_in   = r;
        n_len  = 8'(n);
        @(posedge clk); #1;
        r_load = 1'b0;
        r_m    = r;
        n_m    = n;
    endtask

    // Issue one request and walk all its results; exp_g >= 0 overrides
    // the model for a single request; stall_k stalls at that result.
    task automatic run_req(input string nm, input int t, input int d,
                           input int dt, input int b, input int sw,
                           input int exp_g, input int stall_k);
        int dts[$];
        int lat, exp_lat, delta, top, eg;
        if (sw != 0) begin
            top = (d + 2 < 4) ? d + 2 : 4;
            if (d - 1 > 4) dts.push_back(d - 1);
            else for (int x = d - 1; x <= top; x++) dts.push_back(x);
        end else begin
            dts.push_back(dt);
        end
        delta   = dt - d;
        exp_lat = (sw == 0 && delta >= 1 && delta <= 2) ? 1 + delta : 1;

        req_t     = 8'(t);
        req_d     = 6'(d);
        req_dtag  = 6'(dt);
        req_b     = b[0];
        req_sweep = sw[0];
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({nm, ".lat"}, lat, exp_lat);
        if (!out_valid) return;

        foreach (dts[k]) begin
            eg = (sw == 0 && exp_g >= 0) ? exp_g : gref(t, d, dts[k], b);
            check_eq($sformatf("%s.valid%0d", nm, k), int'(out_valid), 1);
            check_eq($sformatf("%s.gamma%0d", nm, k), int'(out_gamma), eg);
            check_eq($sformatf("%s.dtag%0d", nm, k),
                     int'($signed(out_dtag)), dts[k]);
            check_eq($sformatf("%s.last%0d", nm, k), int'(out_last),
                     (k == dts.size() - 1) ? 1 : 0);
            if (k == stall_k) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    check_eq({nm, ".hold_g"}, int'(out_gamma), eg);
                    check_eq({nm, ".hold_dt"}, int'($signed(out_dtag)), dts[k]);
                    check_eq({nm, ".hold_v"}, int'(out_valid), 1);
                    check_eq({nm, ".hold_rdy"}, int'(req_ready), 0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        check_eq({nm, ".done_v"}, int'(out_valid), 0);
        check_eq({nm, ".done_rdy"}, int'(req_ready), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        r_load    = 1'b0;
        r_in      = '0;
        n_len     = '0;
        req_valid = 1'b0;
        req_t     = '0;
        req_d     = '0;
        req_dtag  = '0;
        req_b     = 1'b0;
        req_sweep = 1'b0;
        out_ready = 1'b1;
        r_m       = '0;
        n_m       = 0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.valid", int'(out_valid), 0);
        check_eq("rst.ready", int'(req_ready), 1);
        check_eq("rst.gamma", int'(out_gamma), 0);
        check_eq("rst.dtag", int'(out_dtag), 0);
        check_eq("rst.last", int'(out_last), 0);
        check_eq("rst.busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        load_r(32'b10101, 5);
        run_req("match", 5, 0, 0, 1, 0, 14563, -1);
        run_req("subst", 2, 0, 0, 1, 0, 7281, -1);
        run_req("t_far", 30, 0, 0, 1, 0, 0, -1);
        run_req("del", 2, 1, 0, 0, 0, 21845, -1);
        run_req("bound", 2, 0, 5, 0, 0, 0, -1);
        run_req("ins1", 1, 0, 1, 0, 0, 2426, -1);
        run_req("ins2", 1, 0, 2, 0, 0, -1, -1);
        run_req("sweep", 1, 0, 0, 0, 1, -1, 1);
        run_req("sw_empty", 3, 6, 0, 0, 1, -1, -1);
        run_req("sw_edge", 2, 3, 0, 1, 1, -1, 0);

        // Reset while CALC is iterating drops the request.
        req_t     = 8'd1;
        req_d     = 6'd0;
        req_dtag  = 6'd2;
        req_b     = 1'b0;
        req_sweep = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("mid.busy", int'(busy), 1);
        rst_n = 1'b0;
        #2;
        check_eq("mid.valid", int'(out_valid), 0);
        check_eq("mid.idle", int'(busy), 0);
        check_eq("mid.ready", int'(req_ready), 1);
        #1 rst_n = 1'b1;
        r_m = '0;
        n_m = 0;
        repeat (4) begin
            @(posedge clk); #1;
            check_eq("mid.quiet", int'(out_valid), 0);
        end
        run_req("empty_r", 1, 0, -1, 0, 0, 21845, -1);

        for (int i = 0; i < 30; i++) begin
            int t, d, dt, b, sw, st;
            if (i % 5 == 0) load_r($urandom, int'($urandom_range(0, 32)));
            t  = int'($urandom_range(0, 34));
            d  = int'($urandom_range(0, 12)) - 6;
            dt = int'($urandom_range(0, 12)) - 6;
            if ($urandom_range(0, 1) == 1) dt = d + int'($urandom_range(0, 3)) - 1;
            b  = int'($urandom_range(0, 1));
            sw = int'($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 3) == 0) ? 0 : -1;
            run_req($sformatf("rnd%0d", i), t, d, dt, b, sw, -1, st);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
